// File: rtl/ex_stage_pkg.sv
// Shared ISA/CPU constants for the execute stage: operation codes, exception codes, fixed widths.
// Optional EX_MUL_EN build adds ALU_OP_MUL; the code points are reserved either way.
package ex_stage_pkg;

   localparam int WORD_W     = 32;
   localparam int PC_W       = 30;
   localparam int REG_ADDR_W = 5;

   typedef enum logic [3:0] {
      ALU_OP_NOP  = 4'd0,
      ALU_OP_AND  = 4'd1,
      ALU_OP_OR   = 4'd2,
      ALU_OP_XOR  = 4'd3,
      ALU_OP_ADDS = 4'd4,
      ALU_OP_ADDU = 4'd5,
      ALU_OP_SUBS = 4'd6,
      ALU_OP_SUBU = 4'd7,
      ALU_OP_SHRL = 4'd8,
      ALU_OP_SHLL = 4'd9,
      ALU_OP_MUL  = 4'd10
   } alu_op_t;

   typedef enum logic [1:0] {
      MEM_OP_NOP = 2'd0,
      MEM_OP_LDW = 2'd1,
      MEM_OP_STW = 2'd2
   } mem_op_t;

   typedef enum logic [1:0] {
      CTRL_OP_NOP  = 2'd0,
      CTRL_OP_WRCR = 2'd1,
      CTRL_OP_EXRT = 2'd2,
      CTRL_OP_TRAP = 2'd3
   } ctrl_op_t;

   typedef enum logic [2:0] {
      ISA_EXP_NO_EXP     = 3'd0,
      ISA_EXP_EXT_INT    = 3'd1,
      ISA_EXP_UNDEF      = 3'd2,
      ISA_EXP_OVERFLOW   = 3'd3,
      ISA_EXP_MISS_ALIGN = 3'd4,
      ISA_EXP_TRAP       = 3'd5,
      ISA_EXP_PRV_VIO    = 3'd6
   } isa_exp_t;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU with signed-overflow detect; zero latency, no flow control.
// EX_MUL_EN enables the single-cycle low-word unsigned multiply on ALU_OP_MUL.
module ex_stage_alu
   import ex_stage_pkg::*;
(
   input  logic [3:0]  alu_op,
   input  logic [31:0] in_0,
   input  logic [31:0] in_1,
   output logic [31:0] result,
   output logic        ovf
);

   always_comb begin
      result = 32'd0;
      case (alu_op_t'(alu_op))
         ALU_OP_NOP:  result = in_0;
         ALU_OP_AND:  result = in_0 & in_1;
         ALU_OP_OR:   result = in_0 | in_1;
         ALU_OP_XOR:  result = in_0 ^ in_1;
         ALU_OP_ADDS,
         ALU_OP_ADDU: result = in_0 + in_1;
         ALU_OP_SUBS,
         ALU_OP_SUBU: result = in_0 - in_1;
         ALU_OP_SHRL: result = in_0 >> in_1[4:0];
         ALU_OP_SHLL: result = in_0 << in_1[4:0];
`ifdef EX_MUL_EN
         ALU_OP_MUL:  result = in_0 * in_1;
`endif
         default:     result = 32'd0;
      endcase
   end

   // Sign-bit rules only; the unsigned variants never trap.
   always_comb begin
      ovf = 1'b0;
      case (alu_op_t'(alu_op))
         ALU_OP_ADDS: ovf = (in_0[31] == in_1[31]) && (result[31] != in_0[31]);
         ALU_OP_SUBS: ovf = (in_0[31] != in_1[31]) && (result[31] != in_0[31]);
         default:     ovf = 1'b0;
      endcase
   end

endmodule

// File: rtl/ex_stage_reg.sv
// EX/MEM pipeline register with reset > flush > stall > load priority; one cycle latency.
// stall holds every field (int_detect ignored); flush and reset load the bubble.
module ex_stage_reg
   import ex_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        int_detect,
   input  logic [29:0] id_pc,
   input  logic        id_en,
   input  logic        id_br_flag,
   input  logic [1:0]  id_mem_op,
   input  logic [31:0] id_mem_wr_data,
   input  logic [1:0]  id_ctrl_op,
   input  logic [4:0]  id_dst_addr,
   input  logic        id_gpr_we_,
   input  logic [2:0]  id_exp_code,
   input  logic [31:0] alu_out,
   input  logic        alu_ovf,
   output logic [29:0] ex_pc,
   output logic        ex_en,
   output logic        ex_br_flag,
   output logic [1:0]  ex_mem_op,
   output logic [31:0] ex_mem_wr_data,
   output logic [1:0]  ex_ctrl_op,
   output logic [4:0]  ex_dst_addr,
   output logic        ex_gpr_we_,
   output logic [2:0]  ex_exp_code,
   output logic [31:0] ex_out
);

   logic       side_kill;
   logic [2:0] exp_nxt;

   // Any exception (or an invalid slot) strips the instruction of its architectural side effects.
   always_comb begin
      side_kill = 1'b1;
      exp_nxt   = ISA_EXP_NO_EXP;
      if (id_en) begin
         if (int_detect) begin
            exp_nxt = ISA_EXP_EXT_INT;
         end else if (id_exp_code != ISA_EXP_NO_EXP) begin
            exp_nxt = id_exp_code;
         end else if (alu_ovf) begin
            exp_nxt = ISA_EXP_OVERFLOW;
         end else begin
            side_kill = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_pc          <= '0;
         ex_en          <= 1'b0;
         ex_br_flag     <= 1'b0;
         ex_mem_op      <= MEM_OP_NOP;
         ex_mem_wr_data <= '0;
         ex_ctrl_op     <= CTRL_OP_NOP;
         ex_dst_addr    <= '0;
         ex_gpr_we_     <= 1'b1;
         ex_exp_code    <= ISA_EXP_NO_EXP;
         ex_out         <= '0;
      end else if (flush) begin
         ex_pc          <= '0;
         ex_en          <= 1'b0;
         ex_br_flag     <= 1'b0;
         ex_mem_op      <= MEM_OP_NOP;
         ex_mem_wr_data <= '0;
         ex_ctrl_op     <= CTRL_OP_NOP;
         ex_dst_addr    <= '0;
         ex_gpr_we_     <= 1'b1;
         ex_exp_code    <= ISA_EXP_NO_EXP;
         ex_out         <= '0;
      end else if (!stall) begin
         ex_pc          <= id_pc;
         ex_en          <= id_en;
         ex_br_flag     <= id_br_flag;
         ex_mem_wr_data <= id_mem_wr_data;
         ex_dst_addr    <= id_dst_addr;
         ex_out         <= alu_out;
         ex_exp_code    <= exp_nxt;
         ex_gpr_we_     <= side_kill ? 1'b1 : id_gpr_we_;
         ex_mem_op      <= side_kill ? MEM_OP_NOP : id_mem_op;
         ex_ctrl_op     <= side_kill ? CTRL_OP_NOP : id_ctrl_op;
      end
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU result forwarded combinationally, registered into ex_* one cycle later.
// stall holds ex_*, flush loads a bubble; build with EX_MUL_EN for the ALU multiply.
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        int_detect,
   input  logic [29:0] id_pc,
   input  logic        id_en,
   input  logic [3:0]  id_alu_op,
   input  logic [31:0] id_alu_in_0,
   input  logic [31:0] id_alu_in_1,
   input  logic        id_br_flag,
   input  logic [1:0]  id_mem_op,
   input  logic [31:0] id_mem_wr_data,
   input  logic [1:0]  id_ctrl_op,
   input  logic [4:0]  id_dst_addr,
   input  logic        id_gpr_we_,
   input  logic [2:0]  id_exp_code,
   output logic [31:0] ex_fwd_data,
   output logic [29:0] ex_pc,
   output logic        ex_en,
   output logic        ex_br_flag,
   output logic [1:0]  ex_mem_op,
   output logic [31:0] ex_mem_wr_data,
   output logic [1:0]  ex_ctrl_op,
   output logic [4:0]  ex_dst_addr,
   output logic        ex_gpr_we_,
   output logic [2:0]  ex_exp_code,
   output logic [31:0] ex_out
);

   logic [31:0] alu_out;
   logic        alu_ovf;

   ex_stage_alu u_alu (
      .alu_op (id_alu_op),
      .in_0   (id_alu_in_0),
      .in_1   (id_alu_in_1),
      .result (alu_out),
      .ovf    (alu_ovf)
   );

   assign ex_fwd_data = alu_out;

   ex_stage_reg u_reg (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .flush          (flush),
      .int_detect     (int_detect),
      .id_pc          (id_pc),
      .id_en          (id_en),
      .id_br_flag     (id_br_flag),
      .id_mem_op      (id_mem_op),
      .id_mem_wr_data (id_mem_wr_data),
      .id_ctrl_op     (id_ctrl_op),
      .id_dst_addr    (id_dst_addr),
      .id_gpr_we_     (id_gpr_we_),
      .id_exp_code    (id_exp_code),
      .alu_out        (alu_out),
      .alu_ovf        (alu_ovf),
      .ex_pc          (ex_pc),
      .ex_en          (ex_en),
      .ex_br_flag     (ex_br_flag),
      .ex_mem_op      (ex_mem_op),
      .ex_mem_wr_data (ex_mem_wr_data),
      .ex_ctrl_op     (ex_ctrl_op),
      .ex_dst_addr    (ex_dst_addr),
      .ex_gpr_we_     (ex_gpr_we_),
      .ex_exp_code    (ex_exp_code),
      .ex_out         (ex_out)
   );

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized traffic against a reference model.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        reset, stall, flush, int_detect;
   logic [29:0] id_pc;
   logic        id_en;
   logic [3:0]  id_alu_op;
   logic [31:0] id_alu_in_0, id_alu_in_1;
   logic        id_br_flag;
   logic [1:0]  id_mem_op;
   logic [31:0] id_mem_wr_data;
   logic [1:0]  id_ctrl_op;
   logic [4:0]  id_dst_addr;
   logic        id_gpr_we_;
   logic [2:0]  id_exp_code;
   logic [31:0] ex_fwd_data;
   logic [29:0] ex_pc;
   logic        ex_en, ex_br_flag;
   logic [1:0]  ex_mem_op;
   logic [31:0] ex_mem_wr_data;
   logic [1:0]  ex_ctrl_op;
   logic [4:0]  ex_dst_addr;
   logic        ex_gpr_we_;
   logic [2:0]  ex_exp_code;
   logic [31:0] ex_out;

   int n_tests = 0;
   int n_fail  = 0;

   // {pc, en, br, mem_op, wr_data, ctrl, dst, we_, exp, out}
   typedef logic [108:0] st_t;
   localparam st_t BUBBLE = {30'd0, 1'b0, 1'b0, 2'd0, 32'd0, 2'd0, 5'd0, 1'b1, 3'd0, 32'd0};

   ex_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .int_detect(int_detect),
      .id_pc(id_pc), .id_en(id_en), .id_alu_op(id_alu_op),
      .id_alu_in_0(id_alu_in_0), .id_alu_in_1(id_alu_in_1),
      .id_br_flag(id_br_flag), .id_mem_op(id_mem_op), .id_mem_wr_data(id_mem_wr_data),
      .id_ctrl_op(id_ctrl_op), .id_dst_addr(id_dst_addr), .id_gpr_we_(id_gpr_we_),
      .id_exp_code(id_exp_code), .ex_fwd_data(ex_fwd_data),
      .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
      .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
      .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out)
   );

   always #5 clk = ~clk;

   function automatic st_t dut_st();
      return {ex_pc, ex_en, ex_br_flag, ex_mem_op, ex_mem_wr_data, ex_ctrl_op,
              ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out};
   endfunction

   function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
      longint unsigned p;
      case (op)
         0:  return a;
         1:  return a & b;
         2:  return a | b;
         3:  return a ^ b;
         4, 5: return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
         6, 7: return 32'((longint'(a) + 64'h1_0000_0000 - longint'(b)) % 64'h1_0000_0000);
         8:  return a >> (b % 32);
         9:  return a << (b % 32);
`ifdef EX_MUL_EN
         10: begin
            p = longint'(a) * longint'(b);
            return p[31:0];
         end
`endif
         default: return 32'd0;
      endcase
   endfunction

   // Overflow judged on true mathematical signed value, not on sign bits.
   function automatic logic ref_ovf(input int op, input logic [31:0] a, input logic [31:0] b);
      longint s;
      if (op == 4)      s = longint'($signed(a)) + longint'($signed(b));
      else if (op == 6) s = longint'($signed(a)) - longint'($signed(b));
      else              return 1'b0;
      return (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction

   function automatic st_t ref_next(input st_t cur);
      logic [2:0] e;
      logic       keep;
      if (reset || flush) return BUBBLE;
      if (stall) return cur;
      keep = 1'b0;
      e    = 3'd0;
      if (id_en) begin
         if (int_detect) e = 3'd1;
         else if (id_exp_code != 3'd0) e = id_exp_code;
         else if (ref_ovf(int'(id_alu_op), id_alu_in_0, id_alu_in_1)) e = 3'd3;
         else keep = 1'b1;
      end
      return {id_pc, id_en, id_br_flag, keep ? id_mem_op : 2'd0, id_mem_wr_data,
              keep ? id_ctrl_op : 2'd0, id_dst_addr, keep ? id_gpr_we_ : 1'b1, e,
              ref_alu(int'(id_alu_op), id_alu_in_0, id_alu_in_1)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic en, input logic we_, input logic [1:0] mem);
      id_alu_op = op; id_alu_in_0 = a; id_alu_in_1 = b;
      id_en = en; id_gpr_we_ = we_; id_mem_op = mem;
      id_pc = 30'h123; id_br_flag = 1'b0; id_mem_wr_data = 32'hCAFE_0001;
      id_ctrl_op = 2'd0; id_dst_addr = 5'd7; id_exp_code = 3'd0;
   endtask

   task automatic test_reset();
      set_id(4'd5, 32'd5, 32'd6, 1'b1, 1'b0, 2'd1);
      tick();
      n_tests++;
      if (ex_en !== 1'b1 || ex_out !== 32'd11) begin
         n_fail++; $display("FAIL reset_preload: en=%b out=%h, required en=1 out=0000000b", ex_en, ex_out);
      end
      #3 reset = 1'b1;
      #1;
      n_tests++;
      if (ex_gpr_we_ !== 1'b1 || ex_en !== 1'b0 || ex_out !== 32'd0) begin
         n_fail++; $display("FAIL reset_async: we_=%b en=%b out=%h, required 1 0 0", ex_gpr_we_, ex_en, ex_out);
      end
      n_tests++;
      if (dut_st() !== BUBBLE) begin
         n_fail++; $display("FAIL reset_bubble: state=%h required %h", dut_st(), BUBBLE);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_overflow();
      set_id(4'd4, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b0, 2'd0);
      #1;
      n_tests++;
      if (ex_fwd_data !== 32'h8000_0000) begin
         n_fail++; $display("FAIL adds_fwd: got %h required 80000000", ex_fwd_data);
      end
      tick();
      n_tests++;
      if (ex_exp_code !== 3'd3 || ex_gpr_we_ !== 1'b1) begin
         n_fail++; $display("FAIL adds_ovf: exp=%0d we_=%b required 3 1", ex_exp_code, ex_gpr_we_);
      end
      set_id(4'd5, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b0, 2'd0);
      tick();
      n_tests++;
      if (ex_exp_code !== 3'd0 || ex_gpr_we_ !== 1'b0 || ex_out !== 32'h8000_0000) begin
         n_fail++; $display("FAIL addu_noovf: exp=%0d we_=%b out=%h required 0 0 80000000",
                            ex_exp_code, ex_gpr_we_, ex_out);
      end
   endtask

   task automatic test_shift_sub();
      set_id(4'd8, 32'h8000_0000, 32'h24, 1'b1, 1'b0, 2'd0);
      #1;
      n_tests++;
      if (ex_fwd_data !== 32'h0800_0000) begin
         n_fail++; $display("FAIL shrl_fwd: got %h required 08000000", ex_fwd_data);
      end
      tick();
      n_tests++;
      if (ex_out !== 32'h0800_0000 || ex_exp_code !== 3'd0) begin
         n_fail++; $display("FAIL shrl_reg: out=%h exp=%0d required 08000000 0", ex_out, ex_exp_code);
      end
      set_id(4'd6, 32'h8000_0000, 32'h1, 1'b1, 1'b0, 2'd0);
      tick();
      n_tests++;
      if (ex_exp_code !== 3'd3 || ex_out !== 32'h7FFF_FFFF) begin
         n_fail++; $display("FAIL subs_ovf: exp=%0d out=%h required 3 7fffffff", ex_exp_code, ex_out);
      end
   endtask

   task automatic test_stall_flush();
      st_t hold;
      set_id(4'd2, 32'hF0, 32'h0F, 1'b1, 1'b0, 2'd1);
      hold = ref_next(BUBBLE);
      tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_id(4'($urandom_range(0, 9)), $urandom, $urandom, 1'b1, 1'b0, 2'd2);
         int_detect = 1'b1;
         tick();
         n_tests++;
         if (dut_st() !== hold) begin
            n_fail++; $display("FAIL stall_hold[%0d]: state=%h required %h", i, dut_st(), hold);
         end
      end
      int_detect = 1'b0;
      flush = 1'b1;
      tick();
      n_tests++;
      if (dut_st() !== BUBBLE) begin
         n_fail++; $display("FAIL stall_flush: state=%h required %h", dut_st(), BUBBLE);
      end
      stall = 1'b0; flush = 1'b0;
   endtask

   task automatic test_int();
      set_id(4'd5, 32'h100, 32'h4, 1'b1, 1'b1, 2'd2);
      int_detect = 1'b1;
      tick();
      n_tests++;
      if (ex_exp_code !== 3'd1 || ex_mem_op !== 2'd0) begin
         n_fail++; $display("FAIL int_en: exp=%0d mem_op=%0d required 1 0", ex_exp_code, ex_mem_op);
      end
      id_en = 1'b0;
      tick();
      n_tests++;
      if (ex_exp_code !== 3'd0 || ex_mem_op !== 2'd0 || ex_en !== 1'b0) begin
         n_fail++; $display("FAIL int_noen: exp=%0d mem_op=%0d en=%b required 0 0 0",
                            ex_exp_code, ex_mem_op, ex_en);
      end
      int_detect = 1'b0;
   endtask

   task automatic test_mul();
      logic [31:0] want;
`ifdef EX_MUL_EN
      want = 32'h0001_0000;
`else
      want = 32'h0;
`endif
      set_id(4'd10, 32'h1_0000, 32'h1_0001, 1'b1, 1'b0, 2'd0);
      tick();
      n_tests++;
      if (ex_out !== want || ex_exp_code !== 3'd0) begin
         n_fail++; $display("FAIL mul: out=%h exp=%0d required %h 0", ex_out, ex_exp_code, want);
      end
   endtask

   task automatic test_random();
      st_t exp_st;
      logic [31:0] spec [4];
      logic [31:0] want_fwd;
      spec[0] = 32'h7FFF_FFFF; spec[1] = 32'h8000_0000; spec[2] = 32'hFFFF_FFFF; spec[3] = 32'h1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      exp_st = BUBBLE;
      for (int i = 0; i < 400; i++) begin
         reset          = ($urandom_range(0, 39) == 0);
         stall          = ($urandom_range(0, 3) == 0);
         flush          = ($urandom_range(0, 7) == 0);
         int_detect     = ($urandom_range(0, 7) == 0);
         id_pc          = 30'($urandom);
         id_en          = ($urandom_range(0, 4) != 0);
         id_alu_op      = 4'($urandom);
         id_alu_in_0    = ($urandom_range(0, 2) == 0) ? spec[$urandom_range(0, 3)] : $urandom;
         id_alu_in_1    = ($urandom_range(0, 2) == 0) ? spec[$urandom_range(0, 3)] : $urandom;
         id_br_flag     = 1'($urandom);
         id_mem_op      = 2'($urandom_range(0, 2));
         id_mem_wr_data = $urandom;
         id_ctrl_op     = 2'($urandom);
         id_dst_addr    = 5'($urandom);
         id_gpr_we_     = 1'($urandom);
         id_exp_code    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 6)) : 3'd0;
         #1;
         want_fwd = ref_alu(int'(id_alu_op), id_alu_in_0, id_alu_in_1);
         n_tests++;
         if (ex_fwd_data !== want_fwd) begin
            n_fail++; $display("FAIL rand_fwd[%0d]: op=%0d got %h required %h", i, id_alu_op, ex_fwd_data, want_fwd);
         end
         exp_st = ref_next(exp_st);
         tick();
         n_tests++;
         if (dut_st() !== exp_st) begin
            n_fail++; $display("FAIL rand_state[%0d]: state=%h required %h", i, dut_st(), exp_st);
         end
      end
      reset = 1'b0; stall = 1'b0; flush = 1'b0; int_detect = 1'b0;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0; int_detect = 1'b0;
      set_id(4'd0, 32'd0, 32'd0, 1'b0, 1'b1, 2'd0);
      #12;
      n_tests++;
      if (dut_st() !== BUBBLE) begin
         n_fail++; $display("FAIL reset_initial: state=%h required %h", dut_st(), BUBBLE);
      end
      reset = 1'b0;
      tick();
      test_reset();
      test_overflow();
      test_shift_sub();
      test_stall_flush();
      test_int();
      test_mul();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
